color_round_ctrl: RTL and testbench

COLOR_ROUND_CTRL -- requirements
Module: color_round_ctrl

---
 rtl/color_pkg.sv | 24 ++
 rtl/color_prng.sv | 36 +++
 rtl/color_round_ctrl.sv | 170 +++++++++++++++++
 tb/tb_color_round_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/color_pkg.sv
// Shared types and constants for the round colour controller.
// Holds the FSM encoding, reset seed, fallback palette and generator step.
package color_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STEP,
    S_PICK,
    S_HOLD
  } state_e;

  localparam logic [31:0] RESET_SEED     = 32'h7FFF_FFFF;
  localparam logic [11:0] FALLBACK_PLATS = 12'b100_011_010_001;
  localparam logic [2:0]  FALLBACK_BALL  = 3'd1;

  // One generator advance: 2*s*s + 5*s + 1, wrapping at 32 bits.
  function automatic logic [31:0] prng_next(input logic [31:0] s);
    logic [31:0] sq;
    sq = s * s;
    return (sq << 1) + (s * 32'd5) + 32'd1;
  endfunction

endpackage

// File: rtl/color_prng.sv
// Quadratic congruential generator feeding the colour draw.
// Load wins over enable; otherwise the state holds.
module color_prng
  import color_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] load_val,
  input  logic        enable,
  output logic [31:0] out
);

  logic [31:0] s_q;
  logic [31:0] s_d;

  always_comb begin
    s_d = s_q;
    if (load) begin
      s_d = load_val;
    end else if (enable) begin
      s_d = prng_next(s_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_q <= RESET_SEED;
    end else begin
      s_q <= s_d;
    end
  end

  assign out = s_q;

endmodule

// File: rtl/color_round_ctrl.sv
// Draws four distinct platform colours and a ball colour per round,
// redrawing on collisions and falling back to a fixed palette.
module color_round_ctrl
  import color_pkg::*;
#(
  parameter int STEPS     = 4,
  parameter int MAX_RETRY = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [7:0]  seed,
  input  logic        ack,
  output logic        busy,
  output logic        valid,
  output logic [11:0] new_color_plats,
  output logic [2:0]  new_color_ball,
  output logic [1:0]  ball_slot,
  output logic [3:0]  retries,
  output logic        fallback
);

  localparam int CW = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] CNT_INIT  = CW'(STEPS - 1);
  localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRY);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    retry_q, retry_d;
  logic [7:0]    seed_q, seed_d;
  logic [11:0]   plats_q, plats_d;
  logic [2:0]    ball_q, ball_d;
  logic [1:0]    slot_q, slot_d;
  logic          fb_q, fb_d;

  logic [31:0] s;
  logic [31:0] load_val;
  logic        prng_load;
  logic        prng_en;

  color_prng u_prng (
    .clk      (clk),
    .reset    (reset),
    .load     (prng_load),
    .load_val (load_val),
    .enable   (prng_en),
    .out      (s)
  );

  assign load_val = s ^ {4{seed_q}};

  logic [2:0] c0, c1, c2, c3;
  logic [1:0] cand_slot;
  logic [2:0] cand_ball;
  logic       cand_ok;

  assign c0        = s[2:0];
  assign c1        = s[10:8];
  assign c2        = s[18:16];
  assign c3        = s[26:24];
  assign cand_slot = s[31:30];

  always_comb begin
    cand_ball = c0;
    unique case (cand_slot)
      2'd0: cand_ball = c0;
      2'd1: cand_ball = c1;
      2'd2: cand_ball = c2;
      2'd3: cand_ball = c3;
      default: cand_ball = c0;
    endcase
  end

  // All nonzero and pairwise distinct.
  assign cand_ok = (c0 != 3'd0) && (c1 != 3'd0) &&
                   (c2 != 3'd0) && (c3 != 3'd0) &&
                   (c0 != c1) && (c0 != c2) && (c0 != c3) &&
                   (c1 != c2) && (c1 != c3) && (c2 != c3);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    retry_d   = retry_q;
    seed_d    = seed_q;
    plats_d   = plats_q;
    ball_d    = ball_q;
    slot_d    = slot_q;
    fb_d      = fb_q;
    prng_load = 1'b0;
    prng_en   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          seed_d  = seed;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        prng_load = 1'b1;
        cnt_d     = CNT_INIT;
        retry_d   = 4'd0;
        state_d   = S_STEP;
      end
      S_STEP: begin
        prng_en = 1'b1;
        if (cnt_q == '0) begin
          state_d = S_PICK;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_PICK: begin
        if (cand_ok) begin
          plats_d = {c3, c2, c1, c0};
          ball_d  = cand_ball;
          slot_d  = cand_slot;
          fb_d    = 1'b0;
          state_d = S_HOLD;
        end else if (retry_q < RETRY_MAX) begin
          retry_d = retry_q + 4'd1;
          cnt_d   = '0;
          state_d = S_STEP;
        end else begin
          plats_d = FALLBACK_PLATS;
          ball_d  = FALLBACK_BALL;
          slot_d  = 2'd0;
          fb_d    = 1'b1;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (ack) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      retry_q <= 4'd0;
      seed_q  <= 8'd0;
      plats_q <= 12'h000;
      ball_q  <= 3'd0;
      slot_q  <= 2'd0;
      fb_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      seed_q  <= seed_d;
      plats_q <= plats_d;
      ball_q  <= ball_d;
      slot_q  <= slot_d;
      fb_q    <= fb_d;
    end
  end

  assign busy            = (state_q != S_IDLE);
  assign valid           = (state_q == S_HOLD);
  assign new_color_plats = plats_q;
  assign new_color_ball  = ball_q;
  assign ball_slot       = slot_q;
  assign retries         = retry_q;
  assign fallback        = fb_q;

endmodule

// File: tb/tb_color_round_ctrl.sv
// Randomised bench for color_round_ctrl against a round-level model.
module tb_color_round_ctrl;
  import color_pkg::*;

  localparam int STEPS = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_i   [2];
  logic [7:0]  seed_i  [2];
  logic        ack_i   [2];
  logic        busy_o  [2];
  logic        valid_o [2];
  logic [11:0] plats_o [2];
  logic [2:0]  ball_o  [2];
  logic [1:0]  slot_o  [2];
  logic [3:0]  retry_o [2];
  logic        fb_o    [2];

  color_round_ctrl #(.STEPS(STEPS), .MAX_RETRY(15)) dut0 (
    .clk(clk), .reset(reset), .req(req_i[0]), .seed(seed_i[0]),
    .ack(ack_i[0]), .busy(busy_o[0]), .valid(valid_o[0]),
    .new_color_plats(plats_o[0]), .new_color_ball(ball_o[0]),
    .ball_slot(slot_o[0]), .retries(retry_o[0]), .fallback(fb_o[0])
  );

  color_round_ctrl #(.STEPS(STEPS), .MAX_RETRY(0)) dut1 (
    .clk(clk), .reset(reset), .req(req_i[1]), .seed(seed_i[1]),
    .ack(ack_i[1]), .busy(busy_o[1]), .valid(valid_o[1]),
    .new_color_plats(plats_o[1]), .new_color_ball(ball_o[1]),
    .ball_slot(slot_o[1]), .retries(retry_o[1]), .fallback(fb_o[1])
  );

  int n_cmp = 0;
  int n_fail = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input int d,
                     input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h want %0h at %0t",
               nm, d, act, exp, $time);
    end
  endtask

  function automatic int maxr(input int d);
    return (d == 0) ? 15 : 0;
  endfunction

  function automatic logic [31:0] gen(input logic [31:0] s);
    logic [63:0] w;
    w = {32'd0, s};
    w = w * w * 2 + w * 5 + 1;
    return w[31:0];
  endfunction

  function automatic bit distinct4(input int col[4]);
    for (int i = 0; i < 4; i++) begin
      if (col[i] == 0) return 0;
      for (int j = i + 1; j < 4; j++)
        if (col[i] == col[j]) return 0;
    end
    return 1;
  endfunction

  function automatic bit good_state(input logic [31:0] s);
    int col[4];
    for (int k = 0; k < 4; k++) col[k] = int'((s >> (8 * k)) & 7);
    return distinct4(col);
  endfunction

  function automatic bit good_plats(input logic [11:0] p);
    int col[4];
    for (int k = 0; k < 4; k++) col[k] = int'((p >> (3 * k)) & 7);
    return distinct4(col);
  endfunction

  // Whole round in one go: seed mix, STEPS advances, redraw loop.
  task automatic draw(input logic [31:0] s_in, input logic [7:0] sd,
                      input int mr, output logic [31:0] s_out,
                      output logic [11:0] pl, output logic [2:0] bl,
                      output logic [1:0] sl, output bit fb, output int r);
    logic [31:0] s;
    bit done;
    s = s_in ^ {sd, sd, sd, sd};
    for (int i = 0; i < STEPS; i++) s = gen(s);
    r = 0;
    done = 0;
    pl = '0; bl = '0; sl = '0; fb = 0;
    while (!done) begin
      if (good_state(s)) begin
        sl = s[31:30];
        pl = 0;
        for (int k = 0; k < 4; k++)
          pl = pl | (12'((s >> (8 * k)) & 7) << (3 * k));
        bl = 3'((s >> (8 * int'(sl))) & 7);
        fb = 0;
        done = 1;
      end else if (r < mr) begin
        r++;
        s = gen(s);
      end else begin
        pl = 12'b100_011_010_001;
        bl = 3'd1;
        sl = 2'd0;
        fb = 1;
        done = 1;
      end
    end
    s_out = s;
  endtask

  logic [31:0] m_s     [2];
  bit          m_busy  [2];
  bit          m_valid [2];
  int          m_cnt   [2];
  logic [11:0] m_pl    [2], p_pl [2];
  logic [2:0]  m_bl    [2], p_bl [2];
  logic [1:0]  m_sl    [2], p_sl [2];
  bit          m_fb    [2], p_fb [2];
  int          m_r     [2], p_r  [2];

  initial forever begin
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        m_s[d] = 32'h7FFF_FFFF;
        m_busy[d] = 0; m_valid[d] = 0; m_cnt[d] = 0;
        m_pl[d] = 0; m_bl[d] = 0; m_sl[d] = 0; m_fb[d] = 0; m_r[d] = 0;
      end else if (!m_busy[d]) begin
        if (req_i[d]) begin
          draw(m_s[d], seed_i[d], maxr(d), m_s[d],
               p_pl[d], p_bl[d], p_sl[d], p_fb[d], p_r[d]);
          m_cnt[d] = STEPS + 2 + 2 * p_r[d];
          m_busy[d] = 1;
        end
      end else if (!m_valid[d]) begin
        m_cnt[d]--;
        if (m_cnt[d] == 0) begin
          m_valid[d] = 1;
          m_pl[d] = p_pl[d]; m_bl[d] = p_bl[d]; m_sl[d] = p_sl[d];
          m_fb[d] = p_fb[d]; m_r[d] = p_r[d];
        end
      end else if (ack_i[d]) begin
        m_busy[d] = 0;
        m_valid[d] = 0;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        chk("busy", d, 32'(busy_o[d]), 32'(m_busy[d]));
        chk("valid", d, 32'(valid_o[d]), 32'(m_valid[d]));
        chk("plats", d, 32'(plats_o[d]), 32'(m_pl[d]));
        chk("ball", d, 32'(ball_o[d]), 32'(m_bl[d]));
        chk("slot", d, 32'(slot_o[d]), 32'(m_sl[d]));
        chk("fallback", d, 32'(fb_o[d]), 32'(m_fb[d]));
        if (valid_o[d]) begin
          chk("retries", d, 32'(retry_o[d]), 32'(m_r[d]));
          chk("slot_inv", d, 32'((plats_o[d] >> (3 * slot_o[d])) & 7),
              32'(ball_o[d]));
          chk("distinct", d, 32'(good_plats(plats_o[d])), 32'd1);
          chk("retry_max", d, 32'(int'(retry_o[d]) <= maxr(d)), 32'd1);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input int d, input logic [7:0] sd, output int exp_lat);
    logic [31:0] so; logic [11:0] pl; logic [2:0] bl; logic [1:0] sl;
    bit fb; int r;
    draw(m_s[d], sd, maxr(d), so, pl, bl, sl, fb, r);
    exp_lat = STEPS + 2 + 2 * r;
    req_i[d] = 1'b1;
    seed_i[d] = sd;
    tick();
    req_i[d] = 1'b0;
    chk("busy_next", d, 32'(busy_o[d]), 32'd1);
  endtask

  task automatic wait_valid(input int d, input bit noisy, output int lat);
    lat = 0;
    while (!valid_o[d] && lat < 100) begin
      if (noisy) req_i[d] = 1'($urandom_range(0, 1));
      tick();
      lat++;
    end
    req_i[d] = 1'b0;
    if (!valid_o[d]) begin
      n_cmp++;
      n_fail++;
      $display("FAIL timeout dut%0d: no valid after %0d cycles", d, lat);
    end
  endtask

  task automatic do_ack(input int d, input bit with_req);
    ack_i[d] = 1'b1;
    req_i[d] = with_req;
    tick();
    ack_i[d] = 1'b0;
    req_i[d] = 1'b0;
  endtask

  task automatic round(input int d, input logic [7:0] sd,
                       output int lat, output logic [11:0] pl);
    int el;
    start(d, sd, el);
    wait_valid(d, 0, lat);
    chk("latency", d, 32'(lat), 32'(el));
    pl = plats_o[d];
  endtask

  initial begin
    int lat, lat1, lat2, el, dly;
    logic [11:0] pl, pl1, pl2, hold_pl;
    logic [2:0] hold_bl;
    logic [31:0] so;
    logic [11:0] tpl; logic [2:0] tbl; logic [1:0] tsl; bit tfb; int tr;
    int fseed;

    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req_i[d] = 0; ack_i[d] = 0; seed_i[d] = 0;
    end
    tick();
    chk_en = 1;
    tick();

    chk("rst_prng", 0, dut0.u_prng.out, 32'h7FFF_FFFF);
    chk("rst_busy", 0, 32'(busy_o[0]), 32'd0);
    chk("rst_plats", 0, 32'(plats_o[0]), 32'd0);
    chk("rst_retries", 0, 32'(retry_o[0]), 32'd0);
    chk("gen0", 0, gen(32'd0), 32'd1);
    chk("gen1", 0, gen(32'd1), 32'd8);
    chk("gen8", 0, gen(32'd8), 32'd169);
    chk("genm1", 0, gen(32'hFFFF_FFFF), 32'hFFFF_FFFE);
    chk("good_a", 0, 32'(good_state(32'h0403_0201)), 32'd1);
    chk("good_b", 0, 32'(good_state(32'h0403_0101)), 32'd0);
    chk("good_c", 0, 32'(good_state(32'h0403_0200)), 32'd0);
    draw(32'h0403_0201 ^ {4{8'h5A}}, 8'h5A, 15, so, tpl, tbl, tsl, tfb, tr);
    reset = 1'b0;
    tick();

    round(0, 8'hA5, lat, pl);
    hold_pl = plats_o[0];
    hold_bl = ball_o[0];
    for (int i = 0; i < 20; i++) begin
      req_i[0] = 1'(i % 2);
      tick();
      chk("hold_plats", 0, 32'(plats_o[0]), 32'(hold_pl));
      chk("hold_ball", 0, 32'(ball_o[0]), 32'(hold_bl));
      chk("hold_valid", 0, 32'(valid_o[0]), 32'd1);
    end
    req_i[0] = 0;
    do_ack(0, 0);
    chk("ack_valid", 0, 32'(valid_o[0]), 32'd0);
    chk("ack_busy", 0, 32'(busy_o[0]), 32'd0);

    fseed = -1;
    for (int sd = 0; sd < 256 && fseed < 0; sd++) begin
      draw(m_s[1], 8'(sd), 0, so, tpl, tbl, tsl, tfb, tr);
      if (tfb) fseed = sd;
    end
    chk("fb_seed_found", 1, 32'(fseed >= 0), 32'd1);
    if (fseed >= 0) begin
      round(1, 8'(fseed), lat, pl);
      chk("fb_plats", 1, 32'(plats_o[1]), 32'h8D1);
      chk("fb_ball", 1, 32'(ball_o[1]), 32'd1);
      chk("fb_slot", 1, 32'(slot_o[1]), 32'd0);
      chk("fb_flag", 1, 32'(fb_o[1]), 32'd1);
      do_ack(1, 0);
    end

    reset = 1'b1; tick(); reset = 1'b0; tick();
    round(0, 8'hA5, lat1, pl1);
    do_ack(0, 0);
    reset = 1'b1; tick(); reset = 1'b0; tick();
    start(0, 8'h3C, el);
    repeat (3) tick();
    reset = 1'b1; tick(); reset = 1'b0; tick();
    round(0, 8'hA5, lat2, pl2);
    chk("replay_lat", 0, 32'(lat2), 32'(lat1));
    chk("replay_plats", 0, 32'(pl2), 32'(pl1));
    do_ack(0, 0);

    for (int n = 0; n < 1000; n++) begin
      start(0, 8'($urandom), el);
      wait_valid(0, 1, lat);
      chk("rnd_lat", 0, 32'(lat), 32'(el));
      dly = $urandom_range(0, 5);
      for (int i = 0; i < dly; i++) begin
        req_i[0] = 1'($urandom_range(0, 1));
        tick();
      end
      do_ack(0, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) tick();
    end

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
